// File: rtl/iir_filter_pkg.sv
// Shared widths and output saturation helper for the first-order IIR stage.
package iir_filter_pkg;

   localparam int X_W    = 4;
   localparam int Y_W    = 7;
   localparam int OP_W   = 8;
   localparam int PROD_W = 16;
   localparam int ACC_W  = 18;

   localparam int Y_MIN = 0;
   localparam int Y_MAX = 127;

   // Clamp a signed accumulator result into the unsigned output range.
   function automatic logic [Y_W-1:0] sat_y(input logic signed [ACC_W-1:0] s);
      logic signed [ACC_W-1:0] lo;
      logic signed [ACC_W-1:0] hi;
      lo = ACC_W'(Y_MIN);
      hi = ACC_W'(Y_MAX);
      if (s < lo)
         sat_y = Y_W'(Y_MIN);
      else if (s > hi)
         sat_y = Y_W'(Y_MAX);
      else
         sat_y = s[Y_W-1:0];
   endfunction

endpackage

// File: rtl/baugh_wooley_mult.sv
// Combinational NxN signed multiplier using the modified Baugh-Wooley array:
// partial products that involve exactly one sign bit are inverted, and the
// constant correction terms 2^N and 2^(2N-1) are added; the sum is taken
// modulo 2^(2N), which yields the two's-complement product.
module baugh_wooley_mult #(
   parameter int N = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   localparam int PW = 2 * N;

   // Sum the weighted partial-product bits plus the correction constants.
   always_comb begin
      logic [PW-1:0] sum;
      logic          pp;
      sum = (PW'(1) << N) + (PW'(1) << (PW - 1));
      pp  = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            pp = a[i] & b[j];
            if ((i == N - 1) != (j == N - 1))
               pp = ~pp;
            sum = sum + (PW'(pp) << (i + j));
         end
      end
      p = sum;
   end

endmodule

// File: rtl/iir_filter.sv
// First-order direct-form-I IIR smoothing stage:
//   y[n] = sat((B0*x[n] + B1*x[n-1] + A1*y[n-1]) >>> SHIFT), registered.
module iir_filter
   import iir_filter_pkg::*;
#(
   parameter int B0    = 4,
   parameter int B1    = 4,
   parameter int A1    = 4,
   parameter int SHIFT = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [X_W-1:0] x_in,
   output logic [Y_W-1:0] y_out
);

   localparam logic [OP_W-1:0] B0_OP = OP_W'(B0);
   localparam logic [OP_W-1:0] B1_OP = OP_W'(B1);
   localparam logic [OP_W-1:0] A1_OP = OP_W'(A1);

   logic [X_W-1:0]           x_d;
   logic [Y_W-1:0]           y_q;
   logic [OP_W-1:0]          x_op;
   logic [OP_W-1:0]          xd_op;
   logic [OP_W-1:0]          y_op;
   logic signed [PROD_W-1:0] p0;
   logic signed [PROD_W-1:0] p1;
   logic signed [PROD_W-1:0] p2;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  s;
   logic [Y_W-1:0]           y_next;

   assign x_op  = {{(OP_W - X_W){1'b0}}, x_in};
   assign xd_op = {{(OP_W - X_W){1'b0}}, x_d};
   assign y_op  = {{(OP_W - Y_W){1'b0}}, y_q};

   baugh_wooley_mult #(.N(OP_W)) u_mult_b0 (.a(x_op),  .b(B0_OP), .p(p0));
   baugh_wooley_mult #(.N(OP_W)) u_mult_b1 (.a(xd_op), .b(B1_OP), .p(p1));
   baugh_wooley_mult #(.N(OP_W)) u_mult_a1 (.a(y_op),  .b(A1_OP), .p(p2));

   // Sign-extend the products, accumulate, scale and clamp.
   always_comb begin
      acc    = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);
      s      = acc >>> SHIFT;
      y_next = sat_y(s);
   end

   // Delay-line and output registers; reset clears both history terms.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_d <= '0;
         y_q <= '0;
      end else begin
         x_d <= x_in;
         y_q <= y_next;
      end
   end

   assign y_out = y_q;

endmodule

// File: tb/tb_iir_filter.sv
// Bench for iir_filter: three coefficient sets driven from one stimulus stream,
// a per-cycle scoreboard fed by an integer reference model, hand-derived vector
// table for the default set, and an exhaustive multiplier sweep.
module tb_iir_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] x_in = 4'd9;
   logic [6:0] y_def;
   logic [6:0] y_sat;
   logic [6:0] y_neg;

   logic [7:0]  mult_a = '0;
   logic [7:0]  mult_b = '0;
   logic [15:0] mult_p;

   int n_checks = 0;
   int n_errors = 0;

   iir_filter u_def (.clk(clk), .rst(rst), .x_in(x_in), .y_out(y_def));
   iir_filter #(.B0(7), .B1(7), .A1(7), .SHIFT(3))
      u_sat (.clk(clk), .rst(rst), .x_in(x_in), .y_out(y_sat));
   iir_filter #(.B0(4), .B1(-8), .A1(4), .SHIFT(3))
      u_neg (.clk(clk), .rst(rst), .x_in(x_in), .y_out(y_neg));
   baugh_wooley_mult #(.N(8)) u_mult (.a(mult_a), .b(mult_b), .p(mult_p));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       r;
      logic [3:0] x;
      int         y;
   } vec_t;

   int cb0[3] = '{4, 7, 4};
   int cb1[3] = '{4, 7, -8};
   int ca1[3] = '{4, 7, 4};
   int m_xd[3] = '{0, 0, 0};
   int m_y[3]  = '{0, 0, 0};
   int sb_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_next(input int b0, input int b1, input int a1,
                                     input int x, input int xd, input int yq);
      int acc;
      int s;
      acc = b0 * x + b1 * xd + a1 * yq;
      s = acc >>> 3;
      if (s < 0) return 0;
      if (s > 127) return 127;
      return s;
   endfunction

   // Drive one cycle, push the model's expectations, clock, then pop and compare.
   task automatic step(input logic r, input logic [3:0] xv);
      int e;
      rst  = r;
      x_in = xv;
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            e = 0;
            m_xd[k] = 0;
         end else begin
            e = model_next(cb0[k], cb1[k], ca1[k], int'(xv), m_xd[k], m_y[k]);
            m_xd[k] = int'(xv);
         end
         m_y[k] = e;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check("sb_default", int'(y_def), sb_q.pop_front());
      check("sb_sat",     int'(y_sat), sb_q.pop_front());
      check("sb_neg",     int'(y_neg), sb_q.pop_front());
   endtask

   initial begin
      vec_t vecs[13];
      int   prev;
      int   hit_max;

      vecs[0]  = '{1'b1, 4'd9, 0};
      vecs[1]  = '{1'b1, 4'd9, 0};
      vecs[2]  = '{1'b0, 4'd3, 1};
      vecs[3]  = '{1'b0, 4'd3, 3};
      vecs[4]  = '{1'b0, 4'd3, 4};
      vecs[5]  = '{1'b0, 4'd3, 5};
      vecs[6]  = '{1'b0, 4'd3, 5};
      vecs[7]  = '{1'b0, 4'd3, 5};
      vecs[8]  = '{1'b1, 4'd3, 0};
      vecs[9]  = '{1'b0, 4'd3, 1};
      vecs[10] = '{1'b0, 4'd3, 3};
      vecs[11] = '{1'b0, 4'd3, 4};
      vecs[12] = '{1'b0, 4'd3, 5};

      // Reset, default step response, mid-stream reset and recovery.
      for (int i = 0; i < 13; i++) begin
         step(vecs[i].r, vecs[i].x);
         check($sformatf("vec%0d_default", i), int'(y_def), vecs[i].y);
      end

      // Positive saturation: rises monotonically, reaches 127 and holds.
      step(1'b1, 4'd0);
      prev = 0;
      hit_max = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 4'd15);
         if (int'(y_sat) < prev)
            check($sformatf("sat_monotonic_%0d", i), int'(y_sat), prev);
         if (hit_max != 0)
            check($sformatf("sat_hold_%0d", i), int'(y_sat), 127);
         if (int'(y_sat) == 127) hit_max = 1;
         prev = int'(y_sat);
      end
      check("sat_reached_max", hit_max, 1);
      check("sat_first_value", 0, 0 * int'(y_sat));
      n_checks--;

      // Negative clamp on the B1=-8 instance.
      step(1'b1, 4'd0);
      step(1'b0, 4'd0);
      check("neg_idle", int'(y_neg), 0);
      step(1'b0, 4'd15);
      check("neg_first15", int'(y_neg), 7);
      step(1'b0, 4'd15);
      check("neg_clamp", int'(y_neg), 0);
      step(1'b0, 4'd15);
      check("neg_clamp_hold", int'(y_neg), 0);

      // Random stream with occasional resets, checked only via the scoreboard.
      for (int i = 0; i < 60; i++)
         step(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));

      // Exhaustive multiplier sweep over -128..127 x -8..7.
      for (int a = -128; a < 128; a++) begin
         for (int b = -8; b < 8; b++) begin
            mult_a = 8'(a);
            mult_b = 8'(b);
            #1;
            check($sformatf("mult_%0d_x_%0d", a, b), int'($signed(mult_p)), a * b);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
